// File: rtl/cn_sp_ctrl_if.sv
// Host-side register and scratchpad-memory bus of the CryptoNight scratchpad controller.
// The host drives the master modport; cn_sp_ctrl sits on the slave modport.
interface cn_sp_ctrl_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int BANKS      = 4
);
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 0;

  logic [7:0]               reg_address;
  logic                     reg_write;
  logic                     reg_read;
  logic [31:0]              reg_wrdata;
  logic [31:0]              reg_rddata;

  logic [ADDR_WIDTH+BW-1:0] mem_address;
  logic                     mem_write;
  logic                     mem_read;
  logic [127:0]             mem_wrdata;
  logic [127:0]             mem_rddata;
  logic                     mem_rdvalid;

  modport master (
    output reg_address, reg_write, reg_read, reg_wrdata,
    input  reg_rddata,
    output mem_address, mem_write, mem_read, mem_wrdata,
    input  mem_rddata, mem_rdvalid
  );

  modport slave (
    input  reg_address, reg_write, reg_read, reg_wrdata,
    output reg_rddata,
    input  mem_address, mem_write, mem_read, mem_wrdata,
    output mem_rddata, mem_rdvalid
  );
endinterface

// File: rtl/cn_sp_ctrl.sv
// Scratchpad banks, seed registers and run control for the CryptoNight memory-loop engine.
// Optional feature: define CN_SP_CYCLE_COUNTER_EN to count RUN cycles in the CYCLES register.
module cn_sp_ctrl #(
  parameter int ADDR_WIDTH = 15,
  parameter int BANKS      = 4,
  parameter int DATA_W     = 128
) (
  input  logic                     clk,
  input  logic                     reset_n,
  cn_sp_ctrl_if.slave              bus,
  output logic                     eng_start,
  output logic                     eng_abort,
  input  logic                     eng_finished,
  input  logic                     eng_ram_we,
  input  logic [ADDR_WIDTH-1:0]    eng_ram_addr,
  input  logic [BANKS*DATA_W-1:0]  eng_ram_wrdata,
  output logic [BANKS*DATA_W-1:0]  eng_ram_rddata,
  output logic [127:0]             eng_ax0,
  output logic [127:0]             eng_bx0,
  output logic [127:0]             eng_bx1,
  output logic                     irq
);

  localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 0;
  localparam int SW    = (BW > 0) ? BW : 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [7:0] REG_CTRL   = 8'h0C;
  localparam logic [7:0] REG_STATUS = 8'h0D;
  localparam logic [7:0] REG_CYCLES = 8'h0E;
  localparam logic [7:0] REG_PARAMS = 8'h0F;
  localparam logic [7:0] P_BANKS    = 8'(BANKS);
  localparam logic [7:0] P_AW       = 8'(ADDR_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic        busy;
  logic        start_req, abort_req, abort_fire;
  logic        irq_en, done, host_reject;
  logic [31:0] seed [12];
  logic [31:0] cycles;
  logic [31:0] rd_mux;
  logic        ctrl_wr, status_wr, seed_wr;

  assign busy      = (state == S_ARM) || (state == S_RUN);
  assign ctrl_wr   = bus.reg_write && (bus.reg_address == REG_CTRL);
  assign status_wr = bus.reg_write && (bus.reg_address == REG_STATUS);
  assign seed_wr   = bus.reg_write && (bus.reg_address < 8'd12) && !busy;

  // ---------------- control register and request pulses ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_req <= 1'b0;
      abort_req <= 1'b0;
      irq_en    <= 1'b0;
    end else begin
      // Abort outranks start when both bits arrive in one write.
      start_req <= ctrl_wr && bus.reg_wrdata[0] && !bus.reg_wrdata[1];
      abort_req <= ctrl_wr && bus.reg_wrdata[1];
      if (ctrl_wr) irq_en <= bus.reg_wrdata[2];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 12; i++) seed[i] <= '0;
    end else if (seed_wr) begin
      seed[bus.reg_address[3:0]] <= bus.reg_wrdata;
    end
  end

  assign eng_ax0 = {seed[3],  seed[2],  seed[1], seed[0]};
  assign eng_bx0 = {seed[7],  seed[6],  seed[5], seed[4]};
  assign eng_bx1 = {seed[11], seed[10], seed[9], seed[8]};

  // ---------------- run state machine ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    state_nx   = state;
    abort_fire = 1'b0;
    case (state)
      S_IDLE: if (start_req) state_nx = S_ARM;
      S_ARM:  state_nx = S_RUN;
      S_RUN: begin
        if (eng_finished) begin
          state_nx = S_DONE;
        end else if (abort_req) begin
          state_nx   = S_IDLE;
          abort_fire = 1'b1;
        end
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign eng_start = (state == S_ARM);
  assign irq       = done & irq_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_abort   <= 1'b0;
      done        <= 1'b0;
      host_reject <= 1'b0;
    end else begin
      eng_abort <= abort_fire;
      if (state == S_DONE)                       done <= 1'b1;
      else if (status_wr && bus.reg_wrdata[1])   done <= 1'b0;
      // A rejection in the same cycle as the clear is kept so it is never lost.
      if (busy && (bus.mem_write || bus.mem_read)) host_reject <= 1'b1;
      else if (status_wr && bus.reg_wrdata[2])     host_reject <= 1'b0;
    end
  end

`ifdef CN_SP_CYCLE_COUNTER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                   cycles <= '0;
    else if (state == S_IDLE && state_nx == S_ARM)  cycles <= '0;
    else if (state == S_RUN && cycles != '1)        cycles <= cycles + 32'd1;
  end
`else
  assign cycles = '0;
`endif

  // ---------------- register read-back ----------------
  always_comb begin
    rd_mux = '0;
    if (bus.reg_address < 8'd12) begin
      rd_mux = seed[bus.reg_address[3:0]];
    end else begin
      case (bus.reg_address)
        REG_CTRL:   rd_mux = {29'b0, irq_en, 2'b00};
        REG_STATUS: rd_mux = {26'b0, 1'b0, state, host_reject, done, busy};
        REG_CYCLES: rd_mux = cycles;
        REG_PARAMS: rd_mux = {16'b0, P_AW, P_BANKS};
        default:    rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          bus.reg_rddata <= '0;
    else if (bus.reg_read) bus.reg_rddata <= rd_mux;
  end

  // ---------------- scratchpad banks ----------------
  logic [SW-1:0]         host_bank;
  logic [ADDR_WIDTH-1:0] host_row;
  logic [ADDR_WIDTH-1:0] bank_addr;
  logic [DATA_W-1:0]     bank_q [BANKS];

  if (BW == 0) begin : g_one_bank
    assign host_bank = '0;
  end else begin : g_multi_bank
    assign host_bank = bus.mem_address[SW-1:0];
  end

  assign host_row  = bus.mem_address[ADDR_WIDTH+BW-1:BW];
  assign bank_addr = busy ? eng_ram_addr : host_row;

  for (genvar k = 0; k < BANKS; k++) begin : g_bank
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] q;
    logic              we;
    logic [DATA_W-1:0] din;

    assign we  = busy ? eng_ram_we : (bus.mem_write && (host_bank == SW'(k)));
    assign din = busy ? eng_ram_wrdata[k*DATA_W +: DATA_W] : bus.mem_wrdata;

    // NOTE: RAM arrays carry no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
      if (we) ram[bank_addr] <= din;
      q <= ram[bank_addr];
    end

    assign bank_q[k]                           = q;
    assign eng_ram_rddata[k*DATA_W +: DATA_W]  = q;
  end

  // Host read: bank select and reject flag travel with the RAM stage, then one output register.
  logic          rd_p1, rej_p1;
  logic [SW-1:0] sel_p1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_p1           <= 1'b0;
      rej_p1          <= 1'b0;
      sel_p1          <= '0;
      bus.mem_rdvalid <= 1'b0;
      bus.mem_rddata  <= '0;
    end else begin
      rd_p1           <= bus.mem_read;
      rej_p1          <= busy;
      sel_p1          <= host_bank;
      bus.mem_rdvalid <= rd_p1;
      if (rd_p1) bus.mem_rddata <= rej_p1 ? '0 : bank_q[sel_p1];
    end
  end

endmodule

// File: doc/cn_sp_ctrl.md
# cn_sp_ctrl

Parametrised scratchpad and run-control front end for the CryptoNight memory-loop engine. It holds the seed registers, the run state machine, status, interrupt and cycle counter, and BANKS inferred scratchpad banks. Ownership of the banks is arbitrated between the host memory port and the engine, and host reads are routed through a correct per-bank read-back mux. It sits between the host Avalon slaves and the memory-loop engine, which connects through the `eng_*` ports.

## Interface
- ADDR_WIDTH, 15, per-bank word address width; bank depth 2^ADDR_WIDTH
- BANKS, 4, bank count; power of two, 1..8; BW = log2(BANKS), with BW = 0 when BANKS = 1
- DATA_W, 128, bank word width; fixed at 128
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- reg_address  in  8  register word address
- reg_write / reg_read  in  1  register access strobes
- reg_wrdata  in  32  write data
- reg_rddata  out  32  read data, registered
- mem_address  in  ADDR_WIDTH+BW  host word address; bank = low BW bits, row = upper bits
- mem_write / mem_read  in  1  host access strobes
- mem_wrdata  in  128  host write data
- mem_rddata  out  128  host read data
- mem_rdvalid  out  1  host read-data strobe
- eng_start  out  1  one-cycle start pulse
- eng_abort  out  1  one-cycle abort pulse
- eng_finished  in  1  engine completion pulse
- eng_ram_we  in  1  engine write enable; applies to all banks
- eng_ram_addr  in  ADDR_WIDTH  engine row address
- eng_ram_wrdata  in  BANKS*128  bank k on bits [128k+127:128k]
- eng_ram_rddata  out  BANKS*128  bank read data, same packing
- eng_ax0 / eng_bx0 / eng_bx1  out  128  seed values
- irq  out  1  level interrupt = done & irq_en

## Operation
- Registers:
  - 0x00–0x03: ax0. 0x04–0x07: bx0. 0x08–0x0B: bx1. Each is a 32-bit slice, LSW first.
  - Seed writes are ignored while busy.
  - 0x0C CTRL: bit0 start (write-1 pulse), bit1 abort (write-1 pulse), bit2 irq_en (R/W).
  - 0x0D STATUS:
    - bit0 busy, read-only.
    - bit1 done, sticky; writing 1 to bit1 clears it.
    - bit2 host_reject, sticky; writing 1 to bit2 clears it.
    - bits[5:3] state encoding.
  - 0x0E CYCLES: read-only, see Configuration.
  - 0x0F PARAMS: [7:0] BANKS, [15:8] ADDR_WIDTH.
  - Unmapped addresses read 0; writes to them are ignored.
- FSM states: IDLE(0), ARM(1), RUN(2), DONE(3).
  - IDLE → ARM on a start write.
  - ARM: eng_start=1 for exactly one cycle, then → RUN.
  - RUN → DONE on eng_finished.
  - RUN → IDLE on abort: eng_abort pulses for one cycle, and done is not set.
  - DONE: sets done for one cycle, then → IDLE.
- Busy = state ∈ {ARM, RUN}. While busy the engine owns every bank: bank address = eng_ram_addr, we = eng_ram_we, din = the bank's slice.
- While not busy the host owns the banks. A host write goes only to bank mem_address[BW-1:0], at row mem_address[ADDR_WIDTH+BW-1:BW].
- Host access while busy:
  - A write is dropped and sets host_reject.
  - A read still produces mem_rdvalid, with mem_rddata = 0, and sets host_reject.
- Host read data is the addressed bank's output. The bank select is pipelined alongside the RAM read.
- eng_finished is ignored outside RUN.
- A start write is ignored in ARM, RUN and DONE.
- Start and abort written in the same CTRL write: abort takes priority. In IDLE this is a no-op.
- eng_finished and abort in the same RUN cycle: finished wins, giving → DONE with no eng_abort pulse.
- Reset mid-run: the FSM returns to IDLE and all registers clear. Bank contents are undefined and not reset.

## Timing
- Reset values:
  - reg_rddata, mem_rddata: 0.
  - mem_rdvalid, eng_start, eng_abort, irq: 0.
  - Seeds: 0. CTRL, STATUS flags, CYCLES: 0.
- reg_rddata: valid 1 cycle after the reg_read cycle; otherwise holds its previous value.
- Banks: synchronous read with 1-cycle latency. eng_ram_rddata is valid the cycle after eng_ram_addr is presented.
- Host read: mem_rdvalid and mem_rddata are valid 2 cycles after mem_read (RAM stage plus output register). Back-to-back reads are supported at one per cycle.
- Ownership follows the registered state. A host access in the same cycle as the IDLE→ARM transition is accepted, because state is still IDLE in that cycle.
- Start write at cycle T:
  - eng_start high at T+2.
  - busy visible in STATUS from T+2.
- eng_finished at cycle F:
  - done = 1 and busy = 0 at F+2.
  - irq high at F+2 if irq_en is set.

## Configuration
- CN_SP_CYCLE_COUNTER_EN
  - Defined: CYCLES counts every clock in RUN, saturates at 0xFFFFFFFF, and clears on the IDLE→ARM transition.
  - Not defined: the counter logic is absent and 0x0E reads 0.

## Test plan
- Seed load: write 0x00–0x0B with 0x11111111..0xCCCCCCCC → eng_ax0 = 0x44444444_33333333_22222222_11111111; eng_bx1[127:96] = 0xCCCCCCCC.
- Host bank routing, BANKS=4:
  - Write addresses 4..7 with data k+0xA0, then read them back → each mem_rddata = 0xA4..0xA7 exactly 2 cycles after its mem_read.
  - eng_ram_rddata row 1 shows the four words in bank order.
- Run:
  - Stimulus: start write; eng_finished 100 cycles after eng_start.
  - Response: single eng_start pulse; busy set; done = 1; irq = 1 with irq_en set.
  - With CN_SP_CYCLE_COUNTER_EN: CYCLES = 100 ±1 fixed offset.
- Ownership:
  - Host write during RUN → bank unchanged, host_reject = 1.
  - Host read during RUN → mem_rdvalid with data 0.
  - W1C write of 0x4 to STATUS clears host_reject.
- Abort/priority:
  - Abort during RUN → eng_abort pulse, IDLE, done = 0.
  - eng_finished coincident with abort → DONE, no eng_abort pulse.
  - Start during RUN → ignored.
- Reset during RUN → all outputs 0 and state IDLE within 1 cycle; a subsequent start works normally.
